platform_rom_arbiter: RTL and testbench
=======================================

Name: platform_rom_arbiter

Overview:
- Shares the single-port on-chip program ROM (1024x32 altsyncram; registered address, unregistered q; byte-enabled debug writes) between two Avalon-MM masters.
- m0 is the CPU instruction master (read-only). m1 is the data/debug master (read/write).
- Arbitrates one command per cycle, tracks in-flight reads through the memory's 1-cycle read latency, and returns registered readdata with readdatavalid.
- Drops non-debug writes and counts them.

Parameters:
- ADDR_W, 10, word address width (1024 words)
- DATA_W, 32, data width
- BE_W, 4, byteenable width (DATA_W/8)
- DROP_CNT_W, 8, width of the dropped-write counter
- RR_ENABLE, 1, 1 = round-robin; 0 = fixed priority with m1 highest

Ports:
- clk in 1: single clock
- reset_n in 1: synchronous, active-low reset
- freeze in 1: when high, no new grants; in-flight reads still complete
- m0_address in ADDR_W: instruction read address
- m0_read in 1: instruction read request
- m0_waitrequest out 1: request not accepted this cycle
- m0_readdata out DATA_W: return data
- m0_readdatavalid out 1: m0_readdata valid
- m1_address in ADDR_W: data address
- m1_read in 1: data read request
- m1_write in 1: data write request
- m1_byteenable in BE_W: write byte lanes
- m1_writedata in DATA_W: write data
- m1_debugaccess in 1: write is from the debug path (the only writes allowed)
- m1_waitrequest out 1: request not accepted this cycle
- m1_readdata out DATA_W: return data
- m1_readdatavalid out 1: m1_readdata valid
- mem_address out ADDR_W: to memory
- mem_byteenable out BE_W: to memory
- mem_chipselect out 1: to memory
- mem_write out 1: to memory
- mem_writedata out DATA_W: to memory
- mem_debugaccess out 1: to memory
- mem_clken out 1: to memory; constant 1
- mem_readdata in DATA_W: memory q, valid the cycle after the address is presented
- drop_count out DROP_CNT_W: saturating count of dropped writes
- busy out 1: a read is in flight, or a request is pending

Behaviour:
- Request qualification:
  - req0 = m0_read.
  - req1 = m1_read | m1_write.
  - If m1_read and m1_write are both high, the write is taken and the read is ignored.
- Grant (cycle T), combinational from registered state:
  - No grant while reset_n is low or freeze is high.
  - Single requester: that master wins.
  - Both requesting, RR_ENABLE=1: the master not equal to last_grant wins.
  - Both requesting, RR_ENABLE=0: m1 wins.
  - last_grant updates on every grant. Reset value is m1, so m0 wins the first contention.
- Waitrequest: mX_waitrequest = reqX & ~grantX. It is combinational, and is also high for requesters while in reset.
- Memory command in cycle T:
  - mem_* are muxed from the winner; mem_chipselect = grant0 | grant1.
  - mem_write = grant1 & m1_write & m1_debugaccess; mem_debugaccess follows it.
  - m0 drives byteenable all-ones and writedata 0.
  - No grant: chipselect=0, write=0, address holds its last value.
- Dropped write: grant1 & m1_write & ~m1_debugaccess.
  - The write is accepted (waitrequest low) but not forwarded.
  - drop_count increments and saturates at all-ones.
- Read pipeline:
  - Stage 1 register (end of T): rd_v, rd_owner.
  - Stage 2 (end of T+1): if rd_v, mem_readdata is registered into the owner's mX_readdata and its readdatavalid is pulsed for one cycle.
  - Read latency = 2 cycles from acceptance; throughput 1 read/cycle, back-to-back across masters.
  - Responses are in order. Only one readdatavalid can be high per cycle.
- Readdata: the non-owner's mX_readdata holds its previous value.
- Writes: produce no response. A write immediately after a read does not disturb the pending return (memory q is for the previous address).
- Freeze:
  - Asserted mid-stream: reads already accepted still return.
  - Deasserted: arbitration resumes the same cycle with last_grant unchanged.
- busy = rd_v | readdatavalid-pending | req0 | req1.
- Reset (synchronous, reset_n=0 at a clk edge):
  - rd_v=0, m0/m1_readdatavalid=0, m0/m1_readdata=0, drop_count=0, last_grant=m1.
  - In-flight reads are discarded; no readdatavalid appears after reset releases.

Decomposition:
- Package platform_rom_pkg:
  - ADDR_W/DATA_W/BE_W defaults
  - owner encoding constants OWN_M0=1'b0, OWN_M1=1'b1
  - READ_LATENCY=2
- One natural sub-module: platform_rom_rr_arb2, a 2-way round-robin/fixed-priority grant with last_grant register and freeze gating. The read-return pipeline stays in the top.

Test Plan:
- Reset, then m0 reads address 0x005 alone: m0_waitrequest=0 in T, mem_address=0x005 chipselect=1 in T; m0_readdatavalid=1 in T+2 with ROM[5].
- m0 and m1 both read continuously (m0 addr 0x010, m1 addr 0x020), RR_ENABLE=1: grants alternate m0,m1,m0,...; readdatavalid alternates one per cycle from T+2; data ROM[0x10]/ROM[0x20].
- m1 write 0xDEADBEEF, byteenable 4'b0011, debugaccess=1 to 0x100, then m1 read 0x100: mem_write=1 once; read returns 0x????BEEF with upper bytes unchanged, 2 cycles later.
- m1 write with debugaccess=0, repeated 300 times: no mem_write ever; waitrequest=0 each time; drop_count saturates at 255.
- m0 read accepted, freeze=1 next cycle while m0/m1 request: the in-flight read still returns at T+2; waitrequest stays high, no mem_chipselect during freeze; grants resume the cycle after freeze=0.
- Read accepted in T, reset_n=0 at the T+1 edge: no readdatavalid ever appears for it; outputs at reset values; first post-reset contention goes to m0.

Source files
------------

// File: rtl/platform_rom_arbiter_pkg.sv
// Shared widths, owner encoding and read latency for the program ROM arbiter.
package platform_rom_pkg;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int BE_W = DATA_W / 8;
    localparam int READ_LATENCY = 2;

    localparam logic OWN_M0 = 1'b0;
    localparam logic OWN_M1 = 1'b1;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [BE_W-1:0] be_t;
endpackage

// File: rtl/platform_rom_arbiter_if.sv
// Avalon-MM bundle between the two masters, the arbiter and the ROM port.
interface platform_rom_arbiter_if;
    import platform_rom_pkg::*;

    addr_t m0_address;
    logic  m0_read;
    logic  m0_waitrequest;
    data_t m0_readdata;
    logic  m0_readdatavalid;

    addr_t m1_address;
    logic  m1_read;
    logic  m1_write;
    be_t   m1_byteenable;
    data_t m1_writedata;
    logic  m1_debugaccess;
    logic  m1_waitrequest;
    data_t m1_readdata;
    logic  m1_readdatavalid;

    addr_t mem_address;
    be_t   mem_byteenable;
    logic  mem_chipselect;
    logic  mem_write;
    data_t mem_writedata;
    logic  mem_debugaccess;
    logic  mem_clken;
    data_t mem_readdata;

    modport slave (
        input  m0_address, m0_read,
        output m0_waitrequest, m0_readdata, m0_readdatavalid,
        input  m1_address, m1_read, m1_write, m1_byteenable,
        input  m1_writedata, m1_debugaccess,
        output m1_waitrequest, m1_readdata, m1_readdatavalid,
        output mem_address, mem_byteenable, mem_chipselect,
        output mem_write, mem_writedata, mem_debugaccess, mem_clken,
        input  mem_readdata
    );

    modport master (
        output m0_address, m0_read,
        input  m0_waitrequest, m0_readdata, m0_readdatavalid,
        output m1_address, m1_read, m1_write, m1_byteenable,
        output m1_writedata, m1_debugaccess,
        input  m1_waitrequest, m1_readdata, m1_readdatavalid,
        input  mem_address, mem_byteenable, mem_chipselect,
        input  mem_write, mem_writedata, mem_debugaccess, mem_clken,
        output mem_readdata
    );
endinterface

// File: rtl/platform_rom_arbiter_arb.sv
// Two-way grant: round-robin or fixed m1 priority, gated by reset and freeze.
module platform_rom_rr_arb2
    import platform_rom_pkg::*;
#(
    parameter int RR_ENABLE = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic freeze_i,
    input  logic req0_i,
    input  logic req1_i,
    output logic gnt0_o,
    output logic gnt1_o
);
    logic last_q;
    logic last_d;
    logic en;
    logic m0_wins;

    always_comb begin
        en      = reset_n & ~freeze_i;
        // on contention m0 only wins under round-robin after an m1 grant
        m0_wins = (RR_ENABLE != 0) && (last_q == OWN_M1);
        gnt0_o  = en & req0_i & (~req1_i | m0_wins);
        gnt1_o  = en & req1_i & ~gnt0_o;
        last_d  = last_q;
        if (gnt0_o)
            last_d = OWN_M0;
        else if (gnt1_o)
            last_d = OWN_M1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            last_q <= OWN_M1;
        else
            last_q <= last_d;
    end
endmodule

// File: rtl/platform_rom_arbiter.sv
// Shares the single-port program ROM between the instruction and data/debug masters.
module platform_rom_arbiter
    import platform_rom_pkg::*;
#(
    parameter int DROP_CNT_W = 8,
    parameter int RR_ENABLE  = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  freeze,
    platform_rom_arbiter_if.slave bus,
    output logic [DROP_CNT_W-1:0] drop_count,
    output logic                  busy
);
    logic req0;
    logic req1;
    logic gnt0;
    logic gnt1;
    logic drop;
    logic rd_acc;
    logic rd_own_d;

    logic                  rd_v_q;
    logic                  rd_own_q;
    logic                  rvalid0_q;
    logic                  rvalid1_q;
    data_t                 rdata0_q;
    data_t                 rdata1_q;
    addr_t                 addr_q;
    addr_t                 addr_d;
    logic [DROP_CNT_W-1:0] drop_q;
    logic [DROP_CNT_W-1:0] drop_d;

    assign req0 = bus.m0_read;
    assign req1 = bus.m1_read | bus.m1_write;

    platform_rom_rr_arb2 #(
        .RR_ENABLE(RR_ENABLE)
    ) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .freeze_i(freeze),
        .req0_i  (req0),
        .req1_i  (req1),
        .gnt0_o  (gnt0),
        .gnt1_o  (gnt1)
    );

    always_comb begin
        bus.m0_waitrequest = req0 & ~gnt0;
        bus.m1_waitrequest = req1 & ~gnt1;
        bus.mem_chipselect = gnt0 | gnt1;
        bus.mem_clken      = 1'b1;
        bus.mem_address    = addr_q;
        bus.mem_byteenable = '1;
        bus.mem_writedata  = '0;
        if (gnt1) begin
            bus.mem_address    = bus.m1_address;
            bus.mem_byteenable = bus.m1_byteenable;
            bus.mem_writedata  = bus.m1_writedata;
        end else if (gnt0) begin
            bus.mem_address = bus.m0_address;
        end
        addr_d = bus.mem_address;
        bus.mem_write       = gnt1 & bus.m1_write & bus.m1_debugaccess;
        bus.mem_debugaccess = bus.mem_write;
        // non-debug writes are acknowledged but never reach the ROM
        drop     = gnt1 & bus.m1_write & ~bus.m1_debugaccess;
        drop_d   = (drop && (drop_q != '1)) ? drop_q + 1'b1 : drop_q;
        rd_acc   = gnt0 | (gnt1 & ~bus.m1_write);
        rd_own_d = gnt1 ? OWN_M1 : OWN_M0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_v_q    <= 1'b0;
            rd_own_q  <= OWN_M0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            addr_q    <= '0;
            drop_q    <= '0;
        end else begin
            rd_v_q    <= rd_acc;
            rd_own_q  <= rd_own_d;
            rvalid0_q <= rd_v_q & (rd_own_q == OWN_M0);
            rvalid1_q <= rd_v_q & (rd_own_q == OWN_M1);
            // ROM q is valid one cycle after the address, i.e. while rd_v_q is set
            if (rd_v_q && (rd_own_q == OWN_M0))
                rdata0_q <= bus.mem_readdata;
            if (rd_v_q && (rd_own_q == OWN_M1))
                rdata1_q <= bus.mem_readdata;
            addr_q <= addr_d;
            drop_q <= drop_d;
        end
    end

    assign bus.m0_readdata      = rdata0_q;
    assign bus.m0_readdatavalid = rvalid0_q;
    assign bus.m1_readdata      = rdata1_q;
    assign bus.m1_readdatavalid = rvalid1_q;
    assign drop_count           = drop_q;
    assign busy                 = rd_v_q | req0 | req1;
endmodule

// File: tb/tb_platform_rom_arbiter.sv
// Directed and random stimulus against a transaction-level model of the arbiter.
module tb_platform_rom_arbiter;
    import platform_rom_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       freeze = 1'b0;
    logic [7:0] drop_count;
    logic       busy;

    platform_rom_arbiter_if bus ();

    platform_rom_arbiter #(
        .DROP_CNT_W(8),
        .RR_ENABLE (1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .freeze    (freeze),
        .bus       (bus),
        .drop_count(drop_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // ROM behaviour: registered address, unregistered q, byte-lane writes
    data_t rom [1024];
    addr_t raddr;
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (bus.mem_write && bus.mem_byteenable[b])
                rom[bus.mem_address][8*b +: 8] <= bus.mem_writedata[8*b +: 8];
        raddr <= bus.mem_address;
    end
    assign bus.mem_readdata = rom[raddr];

    typedef struct {
        int    due;
        bit    own;
        data_t data;
    } rsp_t;

    rsp_t  pend[$];
    data_t ref_mem [1024];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    bit    last_m1 = 1'b1;
    data_t exp_rd0 = '0;
    data_t exp_rd1 = '0;
    int    exp_drop = 0;
    addr_t exp_addr = '0;
    bit    addr_known = 1'b0;

    function automatic data_t rom_init(input int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit r0, input addr_t a0, input bit r1,
                         input bit w1, input addr_t a1, input be_t be,
                         input data_t wd, input bit dbg);
        bus.m0_read        = r0;
        bus.m0_address     = a0;
        bus.m1_read        = r1;
        bus.m1_write       = w1;
        bus.m1_address     = a1;
        bus.m1_byteenable  = be;
        bus.m1_writedata   = wd;
        bus.m1_debugaccess = dbg;
    endtask

    task automatic idle();
        drive(0, '0, 0, 0, '0, '0, '0, 0);
    endtask

    // One clock: check outputs before the edge, then advance the model
    task automatic step();
        bit r0, r1, g0, g1, wr, v0, v1, rst, w1, dbg, pending;
        addr_t a0, a1;
        be_t be;
        data_t wd;
        #1;
        rst = !reset_n;
        r0  = bus.m0_read;
        w1  = bus.m1_write;
        r1  = bus.m1_read || w1;
        dbg = bus.m1_debugaccess;
        a0  = bus.m0_address;
        a1  = bus.m1_address;
        be  = bus.m1_byteenable;
        wd  = bus.m1_writedata;
        g0  = 0;
        g1  = 0;
        if (reset_n && !freeze) begin
            if (r0 && r1) begin
                g0 = last_m1;
                g1 = !last_m1;
            end else begin
                g0 = r0;
                g1 = r1;
            end
        end
        wr = g1 && w1 && dbg;
        chk("m0_waitrequest", 32'(bus.m0_waitrequest), 32'(r0 && !g0));
        chk("m1_waitrequest", 32'(bus.m1_waitrequest), 32'(r1 && !g1));
        chk("mem_chipselect", 32'(bus.mem_chipselect), 32'(g0 || g1));
        chk("mem_write", 32'(bus.mem_write), 32'(wr));
        chk("mem_debugaccess", 32'(bus.mem_debugaccess), 32'(wr));
        chk("mem_clken", 32'(bus.mem_clken), 32'd1);
        if (g0) begin
            chk("mem_address", 32'(bus.mem_address), 32'(a0));
            chk("mem_byteenable", 32'(bus.mem_byteenable), 32'hF);
            chk("mem_writedata", bus.mem_writedata, 32'h0);
        end else if (g1) begin
            chk("mem_address", 32'(bus.mem_address), 32'(a1));
            chk("mem_byteenable", 32'(bus.mem_byteenable), 32'(be));
            chk("mem_writedata", bus.mem_writedata, wd);
        end else if (addr_known) begin
            chk("mem_address_hold", 32'(bus.mem_address), 32'(exp_addr));
        end
        v0 = 0;
        v1 = 0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            if (pend[0].own) begin
                v1 = 1;
                exp_rd1 = pend[0].data;
            end else begin
                v0 = 1;
                exp_rd0 = pend[0].data;
            end
            void'(pend.pop_front());
        end
        pending = pend.size() > 0 && pend[0].due == cyc + 1;
        chk("m0_readdatavalid", 32'(bus.m0_readdatavalid), 32'(v0));
        chk("m1_readdatavalid", 32'(bus.m1_readdatavalid), 32'(v1));
        chk("m0_readdata", bus.m0_readdata, exp_rd0);
        chk("m1_readdata", bus.m1_readdata, exp_rd1);
        chk("drop_count", 32'(drop_count), 32'(exp_drop));
        chk("busy", 32'(busy), 32'(r0 || r1 || pending));
        @(posedge clk);
        if (rst) begin
            last_m1 = 1'b1;
            pend.delete();
            exp_rd0 = '0;
            exp_rd1 = '0;
            exp_drop = 0;
            addr_known = 1'b0;
        end else if (g0) begin
            last_m1 = 1'b0;
            exp_addr = a0;
            addr_known = 1'b1;
            pend.push_back('{cyc + READ_LATENCY, 1'b0, ref_mem[a0]});
        end else if (g1) begin
            last_m1 = 1'b1;
            exp_addr = a1;
            addr_known = 1'b1;
            if (w1 && dbg) begin
                for (int b = 0; b < 4; b++)
                    if (be[b])
                        ref_mem[a1][8*b +: 8] = wd[8*b +: 8];
            end else if (w1) begin
                if (exp_drop < 255)
                    exp_drop++;
            end else begin
                pend.push_back('{cyc + READ_LATENCY, 1'b1, ref_mem[a1]});
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            rom[i] <= rom_init(i);
            ref_mem[i] = rom_init(i);
        end
        idle();
        reset_n = 1'b0;
        freeze = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        step();
        reset_n = 1'b1;

        // lone m0 read
        drive(1, 10'h005, 0, 0, '0, '0, '0, 0);
        step();
        idle();
        repeat (3) step();

        // both masters read continuously
        drive(1, 10'h010, 1, 0, 10'h020, '0, '0, 0);
        repeat (8) step();
        idle();
        repeat (3) step();

        // debug partial write then read back
        drive(0, '0, 0, 1, 10'h100, 4'b0011, 32'hDEAD_BEEF, 1);
        step();
        drive(0, '0, 1, 0, 10'h100, '0, '0, 0);
        step();
        idle();
        repeat (3) step();
        chk("wr_merge", bus.m1_readdata,
            (rom_init(32'h100) & 32'hFFFF_0000) | 32'h0000_BEEF);

        // read immediately followed by a write to the same word
        drive(0, '0, 1, 0, 10'h101, '0, '0, 0);
        step();
        drive(0, '0, 0, 1, 10'h101, 4'b1111, 32'h1234_5678, 1);
        step();
        idle();
        repeat (2) step();

        // non-debug writes, including read+write together
        drive(0, '0, 1, 1, 10'h200, 4'hF, 32'hCAFE_F00D, 0);
        repeat (300) step();
        idle();
        step();
        chk("drop_saturated", 32'(drop_count), 32'd255);

        // freeze while a read is in flight
        drive(1, 10'h033, 0, 0, '0, '0, '0, 0);
        step();
        drive(1, 10'h034, 1, 0, 10'h044, '0, '0, 0);
        freeze = 1'b1;
        repeat (3) step();
        freeze = 1'b0;
        repeat (3) step();
        idle();
        repeat (3) step();

        // reset with a read in flight
        drive(1, 10'h077, 0, 0, '0, '0, '0, 0);
        step();
        drive(1, 10'h078, 1, 0, 10'h079, '0, '0, 0);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        idle();
        repeat (4) step();

        // random traffic
        for (int n = 0; n < 600; n++) begin
            bit w;
            w = ($urandom_range(0, 2) == 0);
            drive(($urandom_range(0, 3) != 0), addr_t'($urandom()),
                  ($urandom_range(0, 2) != 0), w, addr_t'($urandom_range(0, 63)),
                  be_t'($urandom()), $urandom(), ($urandom_range(0, 1) == 1));
            freeze = ($urandom_range(0, 7) == 0);
            reset_n = ($urandom_range(0, 79) != 0);
            step();
        end
        freeze = 1'b0;
        reset_n = 1'b1;
        idle();
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
